// File: rtl/aha_axi_sram_rd_engine_if.sv
// AXI4 read address / read data channel bundle for the SRAM read engine.
// The engine is the slave; the bus master (or bench) drives the AR side and RREADY.
interface aha_axi_sram_rd_engine_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] ARID;
  logic [31:0]         ARADDR;
  logic [7:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;

  logic [ID_WIDTH-1:0] RID;
  logic [63:0]         RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/aha_axi_sram_rd_engine.sv
// AXI4 read engine: turns FIXED/INCR/WRAP bursts into 1-cycle-latency SRAM reads,
// buffering returned words in a 2-entry FIFO so RREADY backpressure never loses data.
module aha_axi_sram_rd_engine #(
  parameter int ID_WIDTH = 4,
  parameter int SRAM_AW  = 12
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  aha_axi_sram_rd_engine_if.slave   axi,
  input  logic                      SRAM_GNT,
  output logic                      SRAM_CEn,
  output logic [SRAM_AW-1:0]        SRAM_ADDR,
  input  logic [63:0]               SRAM_RDATA,
  output logic [1:0]                dbg_state
);

  // Handshakes: a transfer happens on a rising ACLK edge where VALID and READY
  // are both high; VALID never waits on READY, and R outputs hold while RVALID & !RREADY.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q;
  logic [31:0]         addr_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [8:0]          issue_cnt_q;
  logic [8:0]          beat_cnt_q;
  logic                inflight_q;

  logic [63:0]         fifo_data_q [2];
  logic [1:0]          fifo_resp_q [2];
  logic                fifo_last_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          count_q;

  logic                ar_fire, ar_bad, wrap_len_ok;
  logic [8:0]          len_ext;
  logic                beat_last, fifo_empty;
  logic                rvalid, pop;
  logic [63:0]         head_data;
  logic [1:0]          head_resp;
  logic                head_last;
  logic [2:0]          occ;
  logic                issue, err_beat, in_beat, bypass, fifo_wr, fifo_rd;
  logic [63:0]         in_data;
  logic [1:0]          in_resp;
  logic [31:0]         incr, boundary, wrap_mask, addr_next;

  // ---------------- AR acceptance and burst legality ----------------
  assign axi.ARREADY = (state_q == IDLE) && !ARESET;
  assign ar_fire     = axi.ARREADY && axi.ARVALID;
  assign wrap_len_ok = (axi.ARLEN == 8'd1) || (axi.ARLEN == 8'd3) ||
                       (axi.ARLEN == 8'd7) || (axi.ARLEN == 8'd15);
  assign ar_bad      = (axi.ARBURST == 2'b11) || (axi.ARSIZE > 3'd3) ||
                       ((axi.ARBURST == 2'b10) && !wrap_len_ok);

  assign len_ext   = {1'b0, len_q};
  assign beat_last = (beat_cnt_q == len_ext);

  // ---------------- R channel head ----------------
  // With the FIFO empty the word returning from the SRAM is presented directly,
  // giving RVALID two cycles after the AR handshake.
  assign fifo_empty = (count_q == 2'd0);
  assign rvalid     = !ARESET && (!fifo_empty || inflight_q);
  assign pop        = rvalid && axi.RREADY;

  always_comb begin
    head_data = '0;
    head_resp = 2'b00;
    head_last = 1'b0;
    if (!fifo_empty) begin
      head_data = fifo_data_q[rd_ptr_q];
      head_resp = fifo_resp_q[rd_ptr_q];
      head_last = fifo_last_q[rd_ptr_q];
    end else if (inflight_q) begin
      head_data = SRAM_RDATA;
      head_last = beat_last;
    end
  end

  assign axi.RVALID = rvalid;
  assign axi.RDATA  = rvalid ? head_data : 64'd0;
  assign axi.RRESP  = rvalid ? head_resp : 2'b00;
  assign axi.RLAST  = rvalid && head_last;
  assign axi.RID    = id_q;

  // ---------------- SRAM issue and beat generation ----------------
  // occ is the storage still committed after this cycle's pop; an issue needs one free slot.
  assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign issue    = (state_q == BURST) && !ARESET && SRAM_GNT &&
                    (issue_cnt_q <= len_ext) && (occ < 3'd2);
  assign err_beat = (state_q == ERR) && !ARESET &&
                    (beat_cnt_q <= len_ext) && (occ < 3'd2);

  assign in_beat = inflight_q || err_beat;
  assign in_data = inflight_q ? SRAM_RDATA : 64'd0;
  assign in_resp = err_beat ? 2'b10 : 2'b00;
  assign bypass  = fifo_empty && inflight_q && pop;
  assign fifo_wr = in_beat && !bypass;
  assign fifo_rd = pop && !fifo_empty;

  assign SRAM_CEn  = !issue;
  assign SRAM_ADDR = addr_q[SRAM_AW+2:3];
  assign dbg_state = state_q;

  // ---------------- Burst address sequencing ----------------
  assign incr      = 32'd1 << size_q;
  assign boundary  = ({24'd0, len_q} + 32'd1) << size_q;
  assign wrap_mask = boundary - 32'd1;

  always_comb begin
    addr_next = addr_q;
    case (burst_q)
      2'b01:   addr_next = addr_q + incr;
      2'b10:   addr_next = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default: addr_next = addr_q;
    endcase
  end

  // ---------------- State machine ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ar_fire) begin
          state_d = ar_bad ? ERR : BURST;
        end
      end
      BURST, ERR: begin
        if (pop && head_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_resp_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (ar_fire) begin
        id_q        <= axi.ARID;
        addr_q      <= axi.ARADDR;
        len_q       <= axi.ARLEN;
        size_q      <= axi.ARSIZE;
        burst_q     <= axi.ARBURST;
        issue_cnt_q <= '0;
        beat_cnt_q  <= '0;
      end
      if (issue) begin
        addr_q      <= addr_next;
        issue_cnt_q <= issue_cnt_q + 9'd1;
      end
      if (in_beat) begin
        beat_cnt_q <= beat_cnt_q + 9'd1;
      end
      if (fifo_wr) begin
        fifo_data_q[wr_ptr_q] <= in_data;
        fifo_resp_q[wr_ptr_q] <= in_resp;
        fifo_last_q[wr_ptr_q] <= beat_last;
        wr_ptr_q              <= !wr_ptr_q;
      end
      if (fifo_rd) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      count_q <= count_q + {1'b0, fifo_wr} - {1'b0, fifo_rd};
    end
  end

endmodule

// File: tb/tb_aha_axi_sram_rd_engine.sv
// Directed bench for aha_axi_sram_rd_engine: burst vector table plus hand sequences
// for latency, SRAM grant stall and mid-burst reset.
module tb_aha_axi_sram_rd_engine;
  localparam int IDW = 4;
  localparam int AW  = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aha_axi_sram_rd_engine_if #(.ID_WIDTH(IDW)) axi ();
  logic          sram_gnt;
  logic          sram_cen;
  logic [AW-1:0] sram_addr;
  logic [63:0]   sram_rdata;
  logic [1:0]    dbg_state;

  aha_axi_sram_rd_engine #(.ID_WIDTH(IDW), .SRAM_AW(AW)) dut (
    .ACLK       (clk),
    .ARESET     (rst),
    .axi        (axi),
    .SRAM_GNT   (sram_gnt),
    .SRAM_CEn   (sram_cen),
    .SRAM_ADDR  (sram_addr),
    .SRAM_RDATA (sram_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- SRAM model ----------------
  logic [63:0] mem [4096];

  function automatic logic [63:0] pat(int w);
    if (w == 8) return 64'hDEAD;
    return {16'hC0DE, 4'h0, 12'(w), 32'(w) * 32'h9E37_79B9};
  endfunction

  always @(posedge clk) begin
    if (!sram_cen) sram_rdata <= mem[sram_addr];
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [70:0]   exp_q[$];       // {id, last, resp, data}
  logic [AW-1:0] exp_addr_q[$];
  int burst_issues = 0;
  int pops         = 0;
  int outstanding  = 0;
  bit mon_en       = 1'b0;
  bit arr_chk      = 1'b0;
  bit rr_toggle    = 1'b0;
  bit stall_arm    = 1'b0;
  int stall_left   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- RREADY / SRAM_GNT driver ----------------
  initial begin
    axi.RREADY = 1'b1;
    sram_gnt   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_arm && burst_issues == 3) begin
        stall_left = 5;
        stall_arm  = 1'b0;
      end
      if (stall_left > 0) begin
        sram_gnt = 1'b0;
        stall_left--;
      end else begin
        sram_gnt = 1'b1;
      end
      axi.RREADY = rr_toggle ? ~axi.RREADY : 1'b1;
    end
  end

  // ---------------- monitor (samples on falling edge) ----------------
  initial begin
    logic        pop_now;
    logic [70:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        pop_now = axi.RVALID && axi.RREADY;
        if (arr_chk) begin
          check("arready_after_last", axi.ARREADY, 1);
          arr_chk = 1'b0;
        end
        if (!sram_gnt) begin
          check("stall_cen", sram_cen, 1);
          if (exp_addr_q.size() != 0) check("stall_addr", sram_addr, exp_addr_q[0]);
        end
        if (!sram_cen) begin
          check("issue_expected", exp_addr_q.size() != 0, 1);
          check("no_overfill", (outstanding - int'(pop_now)) < 2, 1);
          if (exp_addr_q.size() != 0) check("sram_addr", sram_addr, exp_addr_q.pop_front());
          burst_issues++;
          outstanding++;
        end
        if (pop_now) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rdata", axi.RDATA, e[63:0]);
            check("rresp", axi.RRESP, e[65:64]);
            check("rlast", axi.RLAST, e[66]);
            check("rid",   axi.RID,   e[70:67]);
            if (e[65:64] == 2'b00) outstanding--;
          end
          if (axi.RLAST) arr_chk = 1'b1;
          pops++;
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        rr;
    logic        stall;
    logic        err;
  } vec_t;

  localparam int NV = 12;
  vec_t          vecs [NV];
  logic [11:0]   wtab[$];    // expected SRAM word addresses of all non-error vectors, in order
  int            wbase = 0;

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int c;
    axi.ARID    = id;
    axi.ARADDR  = addr;
    axi.ARLEN   = len;
    axi.ARSIZE  = size;
    axi.ARBURST = burst;
    axi.ARVALID = 1'b1;
    for (c = 0; c < 50; c++) begin
      @(negedge clk);
      if (axi.ARREADY) break;
    end
    check("ar_accept", axi.ARREADY, 1);
    @(posedge clk);
    #1;
    axi.ARVALID = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 400 && (exp_q.size() != 0 || exp_addr_q.size() != 0); c++) @(negedge clk);
    check("drain_beats", exp_q.size(), 0);
    check("drain_addrs", exp_addr_q.size(), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input vec_t v, input logic [3:0] id, input int base);
    logic [63:0] d;
    for (int k = 0; k <= int'(v.len); k++) begin
      d = v.err ? 64'd0 : pat(int'(wtab[base+k]));
      exp_q.push_back({id, (k == int'(v.len)), (v.err ? 2'b10 : 2'b00), d});
      if (!v.err) exp_addr_q.push_back(wtab[base+k]);
    end
  endtask

  task automatic run_vec(input vec_t v, input logic [3:0] id, input int base);
    load_exp(v, id, base);
    burst_issues = 0;
    rr_toggle    = v.rr;
    stall_arm    = v.stall;
    send_ar(id, v.addr, v.len, v.size, v.burst);
    drain();
    check("issue_count", burst_issues, v.err ? 0 : int'(v.len) + 1);
    rr_toggle = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = pat(i);
    sram_rdata  = '0;
    rst         = 1'b1;
    axi.ARVALID = 1'b0;
    axi.ARID    = '0;
    axi.ARADDR  = '0;
    axi.ARLEN   = '0;
    axi.ARSIZE  = '0;
    axi.ARBURST = '0;

    //          addr           len   size  burst  rr    stall err
    vecs[0]  = '{32'h0000_0040, 8'd0,  3'd3, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0100, 8'd7,  3'd3, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'h0000_0018, 8'd3,  3'd3, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0018, 8'd3,  3'd3, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0000, 8'd2,  3'd3, 2'b11, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'h0000_0000, 8'd2,  3'd4, 2'b01, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{32'h0000_0007, 8'd3,  3'd2, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{32'h0000_0038, 8'd7,  3'd3, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000_0008, 8'd2,  3'd3, 2'b10, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{32'h0000_001E, 8'd15, 3'd1, 2'b10, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{32'hFFFF_FFF8, 8'd1,  3'd3, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h0000_0300, 8'd7,  3'd3, 2'b01, 1'b0, 1'b1, 1'b0};

    wtab = '{12'h008,
             12'h020, 12'h021, 12'h022, 12'h023, 12'h024, 12'h025, 12'h026, 12'h027,
             12'h003, 12'h000, 12'h001, 12'h002,
             12'h003, 12'h003, 12'h003, 12'h003,
             12'h000, 12'h001, 12'h001, 12'h002,
             12'h007, 12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006,
             12'h003, 12'h000, 12'h000, 12'h000, 12'h000, 12'h001, 12'h001, 12'h001,
             12'h001, 12'h002, 12'h002, 12'h002, 12'h002, 12'h003, 12'h003, 12'h003,
             12'hFFF, 12'h000,
             12'h060, 12'h061, 12'h062, 12'h063, 12'h064, 12'h065, 12'h066, 12'h067};

    // reset values while reset is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", axi.ARREADY, 0);
    check("rst_rvalid",  axi.RVALID, 0);
    check("rst_rlast",   axi.RLAST, 0);
    check("rst_rid",     axi.RID, 0);
    check("rst_rdata",   axi.RDATA, 0);
    check("rst_rresp",   axi.RRESP, 0);
    check("rst_cen",     sram_cen, 1);
    check("rst_addr",    sram_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_arready", axi.ARREADY, 1);
    check("idle_state",   dbg_state, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // single-beat latency: CEn low one cycle after AR, RVALID the cycle after that
    load_exp(vecs[0], 4'hA, 0);
    burst_issues = 0;
    send_ar(4'hA, 32'h40, 8'd0, 3'd3, 2'b01);
    @(negedge clk);
    check("lat_cen",  sram_cen, 0);
    check("lat_addr", sram_addr, 12'h008);
    @(negedge clk);
    check("lat_rvalid", axi.RVALID, 1);
    check("lat_rlast",  axi.RLAST, 1);
    check("lat_rdata",  axi.RDATA, 64'hDEAD);
    check("lat_rresp",  axi.RRESP, 0);
    drain();

    // table-driven bursts
    wbase = 0;
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], 4'(i + 1), wbase);
      if (!vecs[i].err) wbase += int'(vecs[i].len) + 1;
    end

    // reset after the second beat of an 8-beat burst
    load_exp(vecs[1], 4'h5, 1);
    pops         = 0;
    burst_issues = 0;
    send_ar(4'h5, 32'h100, 8'd7, 3'd3, 2'b01);
    for (int c = 0; c < 100 && pops < 2; c++) @(posedge clk);
    check("rst_mid_pops", pops, 2);
    #1;
    rst    = 1'b1;
    mon_en = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    arr_chk = 1'b0;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    outstanding = 0;
    @(negedge clk);
    check("rst_mid_rvalid",  axi.RVALID, 0);
    check("rst_mid_cen",     sram_cen, 1);
    check("rst_mid_arready", axi.ARREADY, 1);
    @(negedge clk);
    check("rst_mid_rvalid2", axi.RVALID, 0);
    check("rst_mid_state",   dbg_state, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    run_vec(vecs[1], 4'h6, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule
